// File: rtl/mw_lsu_stage.sv
// Memory/writeback stage: issues data-memory accesses over a req/ack bus, stalls upstream while
// an access is outstanding, extends load data and drives the register-file write port.
module mw_lsu_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic [31:0] inst_in,
  input  logic [31:0] wd_in,
  input  logic [31:0] alu_in,
  input  logic [1:0]  wb_sel,
  input  logic        reg_wr,
  input  logic        wr_en,
  input  logic        rd_en,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall_o,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        misalign_o,
  output logic        timeout_o
);
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW:0] TMO_LAST = (CW+1)'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_reg, state_next;
  logic [31:0]     load_q_reg, load_q_next;
  logic [CW-1:0]   tmo_cnt_reg, tmo_cnt_next;
  logic            tmo_flag_reg, tmo_flag_next;

  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [1:0]  off;
  logic        is_byte, is_half, mem_op, is_load, misaligned;
  logic [CW:0] cnt_inc;
  logic        tmo_hit;
  logic [3:0]  be_raw;
  logic [31:0] wdata_raw, ext_data, wb_data;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        req, stall, rf_we_raw, mis_raw, tmo_raw;
  logic        unused_bits;

  assign funct3      = inst_in[14:12];
  assign rd          = inst_in[11:7];
  assign off         = alu_in[1:0];
  assign is_byte     = (funct3[1:0] == 2'b00);
  assign is_half     = (funct3[1:0] == 2'b01);
  assign mem_op      = wr_en | rd_en;
  assign is_load     = rd_en & ~wr_en;
  assign misaligned  = mem_op & (is_byte ? 1'b0 : (is_half ? off[0] : (off != 2'b00)));
  assign cnt_inc     = {1'b0, tmo_cnt_reg} + {{CW{1'b0}}, 1'b1};
  // Abort once the post-increment WAIT count reaches TIMEOUT-1.
  assign tmo_hit     = (cnt_inc >= TMO_LAST);
  assign unused_bits = ^{inst_in[31:15], inst_in[6:0]};

  always_comb begin
    be_raw    = 4'b1111;
    wdata_raw = wd_in;
    ext_data  = dmem_rdata;
    half_sel  = off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (off)
      2'd0:    byte_sel = dmem_rdata[7:0];
      2'd1:    byte_sel = dmem_rdata[15:8];
      2'd2:    byte_sel = dmem_rdata[23:16];
      default: byte_sel = dmem_rdata[31:24];
    endcase
    if (is_byte) begin
      be_raw    = 4'b0001 << off;
      wdata_raw = {4{wd_in[7:0]}};
      ext_data  = {{24{~funct3[2] & byte_sel[7]}}, byte_sel};
    end else if (is_half) begin
      be_raw    = off[1] ? 4'b1100 : 4'b0011;
      wdata_raw = {2{wd_in[15:0]}};
      ext_data  = {{16{~funct3[2] & half_sel[15]}}, half_sel};
    end
  end

  always_comb begin
    case (wb_sel)
      2'b00:   wb_data = pc_in + 32'd4;
      2'b10:   wb_data = load_q_reg;
      default: wb_data = alu_in;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    load_q_next   = load_q_reg;
    tmo_cnt_next  = tmo_cnt_reg;
    tmo_flag_next = tmo_flag_reg;
    req           = 1'b0;
    stall         = 1'b0;
    rf_we_raw     = 1'b0;
    mis_raw       = 1'b0;
    tmo_raw       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!mem_op) begin
          rf_we_raw = reg_wr;
        end else if (misaligned) begin
          mis_raw = 1'b1;
        end else begin
          req           = 1'b1;
          stall         = 1'b1;
          tmo_flag_next = 1'b0;
          if (dmem_ack) begin
            state_next = RESP;
            if (is_load) load_q_next = ext_data;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        req   = 1'b1;
        stall = 1'b1;
        if (dmem_ack) begin
          state_next   = RESP;
          tmo_cnt_next = '0;
          if (is_load) load_q_next = ext_data;
        end else if (tmo_hit) begin
          state_next    = RESP;
          tmo_cnt_next  = '0;
          tmo_flag_next = 1'b1;
        end else begin
          tmo_cnt_next = cnt_inc[CW-1:0];
        end
      end
      RESP: begin
        rf_we_raw     = reg_wr & ~tmo_flag_reg;
        tmo_raw       = tmo_flag_reg;
        tmo_flag_next = 1'b0;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      load_q_reg   <= '0;
      tmo_cnt_reg  <= '0;
      tmo_flag_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      load_q_reg   <= load_q_next;
      tmo_cnt_reg  <= tmo_cnt_next;
      tmo_flag_reg <= tmo_flag_next;
    end
  end

  // Outputs are held at zero combinationally while reset is asserted.
  assign dmem_req   = rst & req;
  assign dmem_we    = rst & req & wr_en;
  assign dmem_addr  = rst ? alu_in : 32'd0;
  assign dmem_wdata = rst ? wdata_raw : 32'd0;
  assign dmem_be    = (rst & req) ? be_raw : 4'b0000;
  assign stall_o    = rst & stall;
  assign rf_we      = rst & rf_we_raw & (rd != 5'd0);
  assign rf_waddr   = rst ? rd : 5'd0;
  assign rf_wdata   = rst ? wb_data : 32'd0;
  assign misalign_o = rst & mis_raw;
  assign timeout_o  = rst & tmo_raw;
endmodule

// File: tb/tb_mw_lsu_stage.sv
// Bench for mw_lsu_stage: directed vector table, reset-during-access sequence and random
// instructions scored against a transaction-level model of the stage.
module tb_mw_lsu_stage;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in, inst_in, wd_in, alu_in;
  logic [1:0]  wb_sel;
  logic        reg_wr, wr_en, rd_en;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        stall_o, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        misalign_o, timeout_o;

  always #5 clk = ~clk;

  mw_lsu_stage #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .inst_in(inst_in), .wd_in(wd_in), .alu_in(alu_in),
    .wb_sel(wb_sel), .reg_wr(reg_wr), .wr_en(wr_en), .rd_en(rd_en),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall_o(stall_o),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .misalign_o(misalign_o),
    .timeout_o(timeout_o)
  );

  typedef struct {
    logic [31:0] pc, inst, wd, alu;
    logic [1:0]  wb;
    logic        reg_wr, wr_en, rd_en;
    int          delay;      // stall-cycle index at which ack is given; -1 = never
    logic [31:0] rdata;
  } stim_t;

  typedef struct {
    int          stalls;
    logic        first_req, we;
    logic [3:0]  be;
    logic [31:0] dwdata;
    logic        rf_we;
    logic [31:0] wdata;
    logic        mis, timeout;
  } exp_t;

  typedef struct {
    int          stalls, req_cycles;
    logic        noisy, hang;
    logic        first_req, first_we;
    logic [3:0]  first_be;
    logic [31:0] first_wdata, first_addr;
    logic        fin_req, rf_we, mis, timeout;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } obs_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  int          total = 0;
  int          bad = 0;
  logic [31:0] model_lq;
  vec_t        tbl[18];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s txn=%0d got=%h want=%h", name, idx, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_inst(input logic [2:0] f3, input logic [4:0] rd);
    return {17'd0, f3, rd, 7'd0};
  endfunction

  function automatic vec_t mkv(input logic [31:0] pc, input logic [2:0] f3, input logic [4:0] rd,
      input logic [31:0] wd, input logic [31:0] alu, input logic [1:0] wb, input logic rw,
      input logic we, input logic re, input int dly, input logic [31:0] rdata,
      input int e_st, input logic e_req, input logic e_we, input logic [3:0] e_be,
      input logic [31:0] e_dw, input logic e_rfwe, input logic [31:0] e_wd,
      input logic e_mis, input logic e_tmo);
    vec_t v;
    v.s.pc = pc; v.s.inst = mk_inst(f3, rd); v.s.wd = wd; v.s.alu = alu; v.s.wb = wb;
    v.s.reg_wr = rw; v.s.wr_en = we; v.s.rd_en = re; v.s.delay = dly; v.s.rdata = rdata;
    v.e.stalls = e_st; v.e.first_req = e_req; v.e.we = e_we; v.e.be = e_be; v.e.dwdata = e_dw;
    v.e.rf_we = e_rfwe; v.e.wdata = e_wd; v.e.mis = e_mis; v.e.timeout = e_tmo;
    return v;
  endfunction

  // Transaction-level model: size/alignment from arithmetic, stall count from the ack delay.
  function automatic exp_t model(input stim_t s);
    exp_t        e;
    logic [2:0]  f3 = s.inst[14:12];
    int          nb = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
    int          off = int'(s.alu % 4);
    logic        memop = s.wr_en | s.rd_en;
    logic        mis = memop && ((s.alu % nb) != 0);
    logic        acked = (s.delay >= 0) && (s.delay < TMO);
    logic [63:0] raw;
    e = '{default: 0};
    e.mis = mis;
    if (memop && !mis) begin
      e.first_req = 1'b1;
      e.we        = s.wr_en;
      e.be        = 4'(((1 << nb) - 1) << off);
      e.stalls    = acked ? s.delay + 1 : TMO;
      e.timeout   = !acked;
      e.dwdata    = (nb == 1) ? s.wd[7:0] * 32'h0101_0101 :
                    ((nb == 2) ? s.wd[15:0] * 32'h0001_0001 : s.wd);
      if (s.rd_en && !s.wr_en && acked) begin
        raw = {32'd0, s.rdata} >> (8 * off);
        raw = raw % (64'd1 << (8 * nb));
        if (f3[2] == 1'b0 && nb < 4 && raw >= (64'd1 << (8 * nb - 1)))
          raw = raw + 64'h1_0000_0000 - (64'd1 << (8 * nb));
        model_lq = raw[31:0];
      end
    end
    e.rf_we = s.reg_wr && (s.inst[11:7] != 5'd0) && !mis && !e.timeout;
    case (s.wb)
      2'b00:   e.wdata = s.pc + 32'd4;
      2'b10:   e.wdata = model_lq;
      default: e.wdata = s.alu;
    endcase
    return e;
  endfunction

  // Enters just after a rising edge, leaves just after the edge that ends the final cycle.
  task automatic run(input stim_t s, output obs_t o);
    int k = 0;
    bit done = 0;
    o = '{default: 0};
    while (!done) begin
      pc_in = s.pc; inst_in = s.inst; wd_in = s.wd; alu_in = s.alu; wb_sel = s.wb;
      reg_wr = s.reg_wr; wr_en = s.wr_en; rd_en = s.rd_en;
      dmem_ack   = (k == s.delay);
      dmem_rdata = (k == s.delay) ? s.rdata : $urandom;
      @(negedge clk);
      if (k == 0) begin
        o.first_req = dmem_req; o.first_we = dmem_we; o.first_be = dmem_be;
        o.first_wdata = dmem_wdata; o.first_addr = dmem_addr;
      end
      if (stall_o) begin
        o.stalls++;
        if (dmem_req) o.req_cycles++;
        if (rf_we | misalign_o | timeout_o) o.noisy = 1'b1;
      end else begin
        o.fin_req = dmem_req; o.rf_we = rf_we; o.mis = misalign_o; o.timeout = timeout_o;
        o.waddr = rf_waddr; o.wdata = rf_wdata;
        done = 1;
      end
      @(posedge clk); #1;
      k++;
      if (!done && k > 100) begin
        o.hang = 1'b1;
        done = 1;
      end
    end
    dmem_ack = 1'b0;
  endtask

  task automatic score(input int idx, input stim_t s, input exp_t e, input obs_t o);
    chk("no_hang", idx, 32'(o.hang), 32'd0);
    chk("stall_cycles", idx, 32'(o.stalls), 32'(e.stalls));
    chk("req_cycles", idx, 32'(o.req_cycles), 32'(e.stalls));
    chk("quiet_while_stalled", idx, 32'(o.noisy), 32'd0);
    chk("first_req", idx, 32'(o.first_req), 32'(e.first_req));
    if (e.first_req) begin
      chk("dmem_we", idx, 32'(o.first_we), 32'(e.we));
      chk("dmem_be", idx, 32'(o.first_be), 32'(e.be));
      chk("dmem_addr", idx, o.first_addr, s.alu);
      if (e.we) chk("dmem_wdata", idx, o.first_wdata, e.dwdata);
    end
    chk("final_req", idx, 32'(o.fin_req), 32'd0);
    chk("rf_we", idx, 32'(o.rf_we), 32'(e.rf_we));
    if (e.rf_we) begin
      chk("rf_wdata", idx, o.wdata, e.wdata);
      chk("rf_waddr", idx, 32'(o.waddr), 32'(s.inst[11:7]));
    end
    chk("misalign_o", idx, 32'(o.mis), 32'(e.mis));
    chk("timeout_o", idx, 32'(o.timeout), 32'(e.timeout));
    $display("txn %0d pc=%h alu=%h we=%0b re=%0b stalls=%0d rf_we=%0b wdata=%h mis=%0b tmo=%0b",
             idx, s.pc, s.alu, s.wr_en, s.rd_en, o.stalls, o.rf_we, o.wdata, o.mis, o.timeout);
  endtask

  initial begin
    stim_t s;
    exp_t  e;
    obs_t  o;

    tbl[0]  = mkv(32'h1000, 3'd0, 5'd5, 0, 32'h1234, 2'b01, 1, 0, 0, -1, 0, 0, 0, 0, 0, 0, 1, 32'h1234, 0, 0);
    tbl[1]  = mkv(32'h1004, 3'd0, 5'd7, 0, 32'h103, 2'b10, 1, 0, 1, 3, 32'h80FF_FF00, 4, 1, 0, 4'b1000, 0, 1, 32'hFFFF_FF80, 0, 0);
    tbl[2]  = mkv(32'h1008, 3'd1, 5'd0, 32'hABCD, 32'h202, 2'b01, 0, 1, 0, 0, 0, 1, 1, 1, 4'b1100, 32'hABCD_ABCD, 0, 0, 0, 0);
    tbl[3]  = mkv(32'h100C, 3'd2, 5'd3, 0, 32'h101, 2'b10, 1, 0, 1, 0, 32'h1111_1111, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[4]  = mkv(32'h1010, 3'd2, 5'd3, 0, 32'h100, 2'b10, 1, 0, 1, -1, 0, 16, 1, 0, 4'b1111, 0, 0, 0, 0, 1);
    tbl[5]  = mkv(32'h1014, 3'd2, 5'd0, 0, 32'h200, 2'b10, 1, 0, 1, 0, 32'h1234_5678, 1, 1, 0, 4'b1111, 0, 0, 0, 0, 0);
    tbl[6]  = mkv(32'h40, 3'd0, 5'd1, 0, 32'h999, 2'b00, 1, 0, 0, -1, 0, 0, 0, 0, 0, 0, 1, 32'h44, 0, 0);
    tbl[7]  = mkv(32'hFFFF_FFFC, 3'd0, 5'd1, 0, 32'h999, 2'b00, 1, 0, 0, -1, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0);
    tbl[8]  = mkv(32'h1018, 3'd0, 5'd2, 0, 32'h55, 2'b10, 1, 0, 0, -1, 0, 0, 0, 0, 0, 0, 1, 32'h1234_5678, 0, 0);
    tbl[9]  = mkv(32'h101C, 3'd5, 5'd4, 0, 32'h102, 2'b10, 1, 0, 1, 1, 32'h80FF_1234, 2, 1, 0, 4'b1100, 0, 1, 32'h0000_80FF, 0, 0);
    tbl[10] = mkv(32'h1020, 3'd1, 5'd4, 0, 32'h102, 2'b10, 1, 0, 1, 1, 32'h80FF_1234, 2, 1, 0, 4'b1100, 0, 1, 32'hFFFF_80FF, 0, 0);
    tbl[11] = mkv(32'h1024, 3'd0, 5'd0, 32'h1234_565A, 32'h1, 2'b01, 0, 1, 0, 0, 0, 1, 1, 1, 4'b0010, 32'h5A5A_5A5A, 0, 0, 0, 0);
    tbl[12] = mkv(32'h1028, 3'd2, 5'd10, 32'hDEAD_BEEF, 32'h10, 2'b01, 1, 1, 1, 2, 32'h7777_7777, 3, 1, 1, 4'b1111, 32'hDEAD_BEEF, 1, 32'h10, 0, 0);
    tbl[13] = mkv(32'h102C, 3'd0, 5'd9, 0, 32'hCAFE, 2'b11, 1, 0, 0, -1, 0, 0, 0, 0, 0, 0, 1, 32'hCAFE, 0, 0);
    tbl[14] = mkv(32'h1030, 3'd1, 5'd0, 32'h1111, 32'h203, 2'b01, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[15] = mkv(32'h1034, 3'd2, 5'd6, 0, 32'h300, 2'b10, 1, 0, 1, 15, 32'h0BAD_F00D, 16, 1, 0, 4'b1111, 0, 1, 32'h0BAD_F00D, 0, 0);
    tbl[16] = mkv(32'h1038, 3'd0, 5'd2, 0, 32'h77, 2'b10, 1, 0, 0, -1, 0, 0, 0, 0, 0, 0, 1, 32'h0BAD_F00D, 0, 0);
    tbl[17] = mkv(32'h103C, 3'd4, 5'd11, 0, 32'h101, 2'b10, 1, 0, 1, 0, 32'h1234_AB00, 1, 1, 0, 4'b0010, 0, 1, 32'h0000_00AB, 0, 0);

    // Reset with a misaligned load applied: every output must stay at zero.
    rst = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'hFFFF_FFFF;
    pc_in = 32'h10; inst_in = mk_inst(3'd2, 5'd5); wd_in = 32'hFFFF_FFFF; alu_in = 32'h101;
    wb_sel = 2'b01; reg_wr = 1'b1; wr_en = 1'b0; rd_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", -1, 32'(dmem_req), 32'd0);
    chk("rst_stall", -1, 32'(stall_o), 32'd0);
    chk("rst_rf_we", -1, 32'(rf_we), 32'd0);
    chk("rst_waddr", -1, 32'(rf_waddr), 32'd0);
    chk("rst_wdata", -1, rf_wdata, 32'd0);
    chk("rst_misalign", -1, 32'(misalign_o), 32'd0);
    chk("rst_addr", -1, dmem_addr, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < 18; i++) begin
      run(tbl[i].s, o);
      score(i, tbl[i].s, tbl[i].e, o);
    end

    // Reset while an access waits: request drops at once, nothing written, load register cleared.
    pc_in = 32'h2000; inst_in = mk_inst(3'd2, 5'd12); alu_in = 32'h400; wb_sel = 2'b10;
    reg_wr = 1'b1; wr_en = 1'b0; rd_en = 1'b1; dmem_ack = 1'b0;
    @(negedge clk);
    chk("mid_issue_req", 100, 32'(dmem_req), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_wait_stall", 100, 32'(stall_o), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_req", 100, 32'(dmem_req), 32'd0);
    chk("mid_rst_stall", 100, 32'(stall_o), 32'd0);
    chk("mid_rst_rf_we", 100, 32'(rf_we), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    inst_in = mk_inst(3'd0, 5'd8); rd_en = 1'b0; wb_sel = 2'b10;
    @(negedge clk);
    chk("post_rst_stall", 100, 32'(stall_o), 32'd0);
    chk("post_rst_rf_we", 100, 32'(rf_we), 32'd1);
    chk("post_rst_load_q", 100, rf_wdata, 32'd0);
    $display("txn 100 reset during WAIT, then pass-through rf_we=%0b wdata=%h", rf_we, rf_wdata);
    @(posedge clk); #1;
    model_lq = 32'd0;

    for (int i = 0; i < 250; i++) begin
      int kind = $urandom_range(0, 9);
      s.pc     = $urandom;
      s.inst   = mk_inst(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
      s.wd     = $urandom;
      s.alu    = $urandom;
      if ($urandom_range(0, 1) == 0) s.alu[1:0] = 2'b00;
      s.wb     = 2'($urandom_range(0, 3));
      s.reg_wr = 1'($urandom_range(0, 3) != 0);
      s.wr_en  = (kind >= 6 && kind <= 8);
      s.rd_en  = (kind >= 3 && kind <= 5) || kind == 8;
      s.delay  = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 18) : $urandom_range(0, 3);
      s.rdata  = $urandom;
      e = model(s);
      run(s, o);
      score(200 + i, s, e, o);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
